// File: rtl/csr_access_unit.sv
// Zicsr execute-stage sequencer: issues one access strobe to the CSR file, captures the old value, returns rd writeback.
// Latency: legal response 3 cycles after accept, illegal 1 cycle; rsp held until rsp_ready, no accept outside IDLE.
module csr_access_unit #(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [CSR_ADDR_W-1:0] req_csr,
  input  logic [4:0]            req_rs1,
  input  logic [4:0]            req_rd,
  input  logic [XLEN-1:0]       req_rs1_value,
  output logic [2:0]            csr_operation,
  output logic [CSR_ADDR_W-1:0] csr_number,
  output logic [4:0]            csr_rs1,
  output logic [XLEN-1:0]       csr_input_value,
  output logic                  csr_write_enable,
  input  logic [XLEN-1:0]       csr_value,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [4:0]            rsp_rd,
  output logic                  rsp_rd_we,
  output logic [XLEN-1:0]       rsp_value,
  output logic                  rsp_illegal
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  state, state_next;
  logic                    accept;
  logic                    req_illegal;
  logic [2:0]              op_q;
  logic [CSR_ADDR_W-1:0]   num_q;
  logic [4:0]              rs1_q;
  logic [4:0]              rd_q;
  logic [XLEN-1:0]         operand_q;
  logic [XLEN-1:0]         value_q;
  logic                    illegal_q;

  assign accept = req_valid && req_ready;
  // funct3 low bits 00 are not CSR ops; top two address bits 11 are the read-only space
  assign req_illegal = (req_funct3[1:0] == 2'b00) ||
                       (req_csr[CSR_ADDR_W-1 -: 2] == 2'b11);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Strobes are masked by reset so an abort mid-ISSUE never reaches the file
  always_comb begin
    state_next       = state;
    req_ready        = 1'b0;
    csr_write_enable = 1'b0;
    rsp_valid        = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (accept) state_next = req_illegal ? RESP : ISSUE;
      end
      ISSUE: begin
        csr_write_enable = !reset;
        state_next       = WAIT;
      end
      WAIT: state_next = RESP;
      RESP: begin
        rsp_valid = !reset;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= '0;
      num_q     <= '0;
      rs1_q     <= '0;
      rd_q      <= '0;
      operand_q <= '0;
      value_q   <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      op_q      <= req_funct3;
      num_q     <= req_csr;
      rs1_q     <= req_rs1;
      rd_q      <= req_rd;
      operand_q <= req_funct3[2] ? {{(XLEN-5){1'b0}}, req_rs1} : req_rs1_value;
      value_q   <= '0;
      illegal_q <= req_illegal;
    end else if (state == WAIT) begin
      value_q   <= csr_value;
    end
  end

  assign csr_operation   = op_q;
  assign csr_number      = num_q;
  assign csr_rs1         = rs1_q;
  assign csr_input_value = operand_q;
  assign rsp_rd          = rd_q;
  assign rsp_value       = value_q;
  assign rsp_illegal     = illegal_q;
  assign rsp_rd_we       = !illegal_q && (rd_q != 5'd0);

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a registered CSR-file model and a response scoreboard.
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rd;
  logic [31:0] req_rs1_value;
  logic [2:0]  csr_operation;
  logic [11:0] csr_number;
  logic [4:0]  csr_rs1;
  logic [31:0] csr_input_value;
  logic        csr_write_enable;
  logic [31:0] csr_value = '0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_rd;
  logic        rsp_rd_we;
  logic [31:0] rsp_value;
  logic        rsp_illegal;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] value;
    logic        illegal;
    logic [31:0] input_val;
    int          lat;
    int          writes;
  } exp_t;

  exp_t sb[$];

  csr_access_unit #(.XLEN(32), .CSR_ADDR_W(12)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_csr(req_csr), .req_rs1(req_rs1), .req_rd(req_rd), .req_rs1_value(req_rs1_value),
    .csr_operation(csr_operation), .csr_number(csr_number), .csr_rs1(csr_rs1),
    .csr_input_value(csr_input_value), .csr_write_enable(csr_write_enable),
    .csr_value(csr_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
    .rsp_rd_we(rsp_rd_we), .rsp_value(rsp_value), .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  // CSR file model: registered old-value return, read-modify-write on the strobe
  logic [31:0] csr_mem [4096];
  int          writes = 0;
  logic [31:0] last_input = '0;

  initial begin
    for (int i = 0; i < 4096; i++) csr_mem[i] = '0;
    csr_mem[12'h301] = 32'h4000_0100;
  end

  always @(posedge clk) begin
    if (csr_write_enable) begin
      writes     <= writes + 1;
      last_input <= csr_input_value;
      csr_value  <= csr_mem[csr_number];
      case (csr_operation[1:0])
        2'b01:   csr_mem[csr_number] <= csr_input_value;
        2'b10:   csr_mem[csr_number] <= csr_mem[csr_number] | csr_input_value;
        2'b11:   csr_mem[csr_number] <= csr_mem[csr_number] & ~csr_input_value;
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input string name, input logic [2:0] f3, input logic [11:0] csr,
                      input logic [4:0] rs1, input logic [4:0] rd, input logic [31:0] rs1v,
                      input logic ill, input logic [31:0] exp_val, input logic [31:0] exp_in,
                      input int hold);
    exp_t e;
    int   k;
    int   w0;
    e.rd        = rd;
    e.rd_we     = !ill && (rd != 5'd0);
    e.value     = ill ? 32'h0 : exp_val;
    e.illegal   = ill;
    e.input_val = exp_in;
    e.lat       = ill ? 1 : 3;
    e.writes    = ill ? 0 : 1;
    sb.push_back(e);

    @(negedge clk);
    check({name, ".req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_funct3 = f3; req_csr = csr;
    req_rs1 = rs1; req_rd = rd; req_rs1_value = rs1v;
    w0 = writes;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      req_valid = 1'b0;
    end while (!rsp_valid && k < 8);

    e = sb.pop_front();
    check({name, ".latency"}, 64'(k), 64'(e.lat));
    check({name, ".rsp_rd"}, 64'(rsp_rd), 64'(e.rd));
    check({name, ".rd_we"}, 64'(rsp_rd_we), 64'(e.rd_we));
    check({name, ".value"}, 64'(rsp_value), 64'(e.value));
    check({name, ".illegal"}, 64'(rsp_illegal), 64'(e.illegal));
    if (e.writes != 0) begin
      check({name, ".input"}, 64'(last_input), 64'(e.input_val));
      check({name, ".csr_num"}, 64'(csr_number), 64'(csr));
    end

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, ".hold_vld"}, 64'({rsp_valid, req_ready}), 64'(2'b10));
      check({name, ".hold_val"}, 64'({rsp_rd_we, rsp_illegal, rsp_rd, rsp_value}),
            64'({e.rd_we, e.illegal, e.rd, e.value}));
    end

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, ".done"}, 64'({rsp_valid, req_ready}), 64'(2'b01));
    check({name, ".writes"}, 64'(writes - w0), 64'(e.writes));
  endtask

  initial begin
    int w0;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_funct3 = '0; req_csr = '0; req_rs1 = '0; req_rd = '0; req_rs1_value = '0;

    repeat (3) @(negedge clk);
    check("rst.ctrl", 64'({req_ready, rsp_valid, csr_write_enable, rsp_rd_we, rsp_illegal}), 64'd0);
    check("rst.csr", 64'({csr_operation, csr_number, csr_rs1, csr_input_value}), 64'd0);
    check("rst.rsp", 64'({rsp_rd, rsp_value}), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst.ready", 64'(req_ready), 64'd1);

    send("csrrw",   3'b001, 12'h340, 5'd5,  5'd3, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 0);
    send("csrrs0",  3'b010, 12'h340, 5'd0,  5'd4, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 0);
    send("csrrsi",  3'b110, 12'h301, 5'h1F, 5'd5, 32'hFFFF_0000, 1'b0, 32'h4000_0100, 32'h0000_001F, 0);
    send("misa_rd", 3'b010, 12'h301, 5'd0,  5'd6, 32'h0000_0000, 1'b0, 32'h4000_011F, 32'h0000_0000, 0);
    send("ro_csr",  3'b001, 12'hC00, 5'd1,  5'd7, 32'h1234_5678, 1'b1, 32'h0,        32'h0,         0);
    send("f3_000",  3'b000, 12'h340, 5'd1,  5'd8, 32'h1234_5678, 1'b1, 32'h0,        32'h0,         0);
    send("f3_100",  3'b100, 12'h340, 5'd1,  5'd9, 32'h1234_5678, 1'b1, 32'h0,        32'h0,         0);
    send("csrrc_h", 3'b011, 12'h340, 5'd2,  5'd0, 32'h0000_BEEF, 1'b0, 32'hDEAD_BEEF, 32'h0000_BEEF, 5);
    send("csrrci",  3'b111, 12'h340, 5'd0,  5'd1, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_0000, 32'h0000_0000, 0);

    // Reset asserted while the unit is in ISSUE must suppress the strobe
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b001; req_csr = 12'h340;
    req_rs1 = 5'd3; req_rd = 5'd2; req_rs1_value = 32'h1234_5678;
    w0 = writes;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("abort.we", 64'(csr_write_enable), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort.idle", 64'({req_ready, rsp_valid}), 64'(2'b10));
    check("abort.writes", 64'(writes - w0), 64'd0);
    send("post_abort", 3'b010, 12'h340, 5'd0, 5'd2, 32'h0, 1'b0, 32'hDEAD_0000, 32'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
